// File: rtl/cpu_6502_pkg.sv
// Shared definitions for the 6502 read-modify-write sequencer: ALU function
// codes, RMW op codes, FSM state encoding and bus/flag payload structs.
package cpu_6502_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned FUNC_W = 4;
  localparam int unsigned OP_W   = 3;

  typedef enum logic [FUNC_W-1:0] {
    F_AND = 4'h0,
    F_ORA = 4'h1,
    F_EOR = 4'h2,
    F_ADC = 4'h3,
    F_SBC = 4'h4,
    F_INC = 4'h5,
    F_CMP = 4'h6,
    F_DEC = 4'h7,
    F_ASL = 4'h8,
    F_LSR = 4'h9,
    F_ROL = 4'hA,
    F_ROR = 4'hB,
    F_BIT = 4'hC,
    F_NOP = 4'hF
  } alu_func_e;

  typedef enum logic [OP_W-1:0] {
    OP_ASL = 3'd0,
    OP_LSR = 3'd1,
    OP_ROL = 3'd2,
    OP_ROR = 3'd3,
    OP_INC = 3'd4,
    OP_DEC = 3'd5
  } rmw_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_MODIFY = 2'd2,
    S_WRITE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  typedef struct packed {
    alu_func_e         func;
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
    logic              c;
  } alu_req_t;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic we_c;
    logic we_zn;
  } flag_t;

  localparam alu_req_t ALU_IDLE = '{func: F_NOP, left: '0, right: '0, c: 1'b0};

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_W'(OP_DEC);
  endfunction

  function automatic alu_func_e op_func(input rmw_op_e op);
    case (op)
      OP_ASL:  return F_ASL;
      OP_LSR:  return F_LSR;
      OP_ROL:  return F_ROL;
      OP_ROR:  return F_ROR;
      OP_INC:  return F_INC;
      OP_DEC:  return F_DEC;
      default: return F_NOP;
    endcase
  endfunction

  // Shifts and rotates update carry; INC/DEC only touch Z and N.
  function automatic logic op_sets_c(input rmw_op_e op);
    return (op == OP_ASL) || (op == OP_LSR) || (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/cpu_6502_rmw_seq.sv
// Read-modify-write memory sequencer (ASL/LSR/ROL/ROR/INC/DEC) driving an
// external ALU. Define RMW_DUMMY_WRITE_EN to emit the 6502 dummy write in MODIFY.
module cpu_6502_rmw_seq
  import cpu_6502_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [OP_W-1:0]   i_op,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_c,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic              o_bus_rd,
  output logic              o_bus_wr,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic [DATA_W-1:0] i_bus_rdata,
  input  logic              i_rdy,
  output logic [FUNC_W-1:0] o_alu_func,
  output logic [DATA_W-1:0] o_alu_left,
  output logic [DATA_W-1:0] o_alu_right,
  output logic              o_alu_c,
  input  logic [DATA_W-1:0] i_alu_q,
  input  logic              i_alu_c,
  input  logic              i_alu_z,
  input  logic              i_alu_n,
  output logic              o_flag_c,
  output logic              o_flag_z,
  output logic              o_flag_n,
  output logic              o_flag_we_c,
  output logic              o_flag_we_zn
);

  state_e            state, state_nxt;
  rmw_op_e           op_q, op_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic              c_q, c_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;

  bus_req_t bus_q, bus_nxt;
  alu_req_t alu_q, alu_nxt;
  flag_t    flag_q, flag_nxt;
  logic     busy_q, busy_nxt;
  logic     done_q, done_nxt;

  // State and operand registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= S_IDLE;
      op_q   <= OP_ASL;
      addr_q <= '0;
      c_q    <= 1'b0;
      data_q <= '0;
    end else begin
      state  <= state_nxt;
      op_q   <= op_nxt;
      addr_q <= addr_nxt;
      c_q    <= c_nxt;
      data_q <= data_nxt;
    end
  end

  // Outputs are registered from the decode of the state being entered, so each
  // lands in the same cycle as its state with no path from bus/ALU inputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      bus_q  <= '0;
      alu_q  <= ALU_IDLE;
      flag_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bus_q  <= bus_nxt;
      alu_q  <= alu_nxt;
      flag_q <= flag_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    addr_nxt  = addr_q;
    c_nxt     = c_q;
    data_nxt  = data_q;
    bus_nxt   = '0;
    alu_nxt   = ALU_IDLE;
    flag_nxt  = '0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;

    case (state)
      S_IDLE: begin
        if (i_start && op_legal(i_op)) begin
          state_nxt = S_READ;
          op_nxt    = rmw_op_e'(i_op);
          addr_nxt  = i_addr;
          c_nxt     = i_c;
        end
      end
      S_READ: begin
        if (i_rdy) begin
          state_nxt = S_MODIFY;
          data_nxt  = i_bus_rdata;
        end
      end
      S_MODIFY: state_nxt = S_WRITE;
      S_WRITE:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_READ: begin
        busy_nxt     = 1'b1;
        bus_nxt.rd   = 1'b1;
        bus_nxt.addr = addr_nxt;
      end
      S_MODIFY: begin
        busy_nxt      = 1'b1;
        alu_nxt.func  = op_func(op_nxt);
        alu_nxt.left  = data_nxt;
        alu_nxt.right = '0;
        alu_nxt.c     = c_nxt;
`ifdef RMW_DUMMY_WRITE_EN
        bus_nxt.wr    = 1'b1;
        bus_nxt.addr  = addr_nxt;
        bus_nxt.wdata = data_nxt;
`endif
      end
      S_WRITE: begin
        busy_nxt       = 1'b1;
        done_nxt       = 1'b1;
        bus_nxt.wr     = 1'b1;
        bus_nxt.addr   = addr_nxt;
        bus_nxt.wdata  = i_alu_q;
        flag_nxt.c     = i_alu_c;
        flag_nxt.z     = i_alu_z;
        flag_nxt.n     = i_alu_n;
        flag_nxt.we_zn = 1'b1;
        flag_nxt.we_c  = op_sets_c(op_nxt);
      end
      default: ;
    endcase
  end

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_bus_addr   = bus_q.addr;
  assign o_bus_rd     = bus_q.rd;
  assign o_bus_wr     = bus_q.wr;
  assign o_bus_wdata  = bus_q.wdata;
  assign o_alu_func   = alu_q.func;
  assign o_alu_left   = alu_q.left;
  assign o_alu_right  = alu_q.right;
  assign o_alu_c      = alu_q.c;
  assign o_flag_c     = flag_q.c;
  assign o_flag_z     = flag_q.z;
  assign o_flag_n     = flag_q.n;
  assign o_flag_we_c  = flag_q.we_c;
  assign o_flag_we_zn = flag_q.we_zn;

endmodule

// File: tb/tb_cpu_6502_rmw_seq.sv
// Self-checking bench for cpu_6502_rmw_seq: directed and random RMW operations
// against an arithmetic reference model, with a behavioural external ALU.
module tb_cpu_6502_rmw_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_start;
  logic [2:0]  i_op;
  logic [15:0] i_addr;
  logic        i_c;
  logic        o_busy, o_done;
  logic [15:0] o_bus_addr;
  logic        o_bus_rd, o_bus_wr;
  logic [7:0]  o_bus_wdata;
  logic [7:0]  i_bus_rdata;
  logic        i_rdy;
  logic [3:0]  o_alu_func;
  logic [7:0]  o_alu_left, o_alu_right;
  logic        o_alu_c;
  logic [7:0]  alu_q;
  logic        alu_c, alu_z, alu_n;
  logic        o_flag_c, o_flag_z, o_flag_n, o_flag_we_c, o_flag_we_zn;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_6502_rmw_seq dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_start(i_start), .i_op(i_op), .i_addr(i_addr), .i_c(i_c),
    .o_busy(o_busy), .o_done(o_done),
    .o_bus_addr(o_bus_addr), .o_bus_rd(o_bus_rd), .o_bus_wr(o_bus_wr),
    .o_bus_wdata(o_bus_wdata), .i_bus_rdata(i_bus_rdata), .i_rdy(i_rdy),
    .o_alu_func(o_alu_func), .o_alu_left(o_alu_left), .o_alu_right(o_alu_right),
    .o_alu_c(o_alu_c), .i_alu_q(alu_q), .i_alu_c(alu_c), .i_alu_z(alu_z), .i_alu_n(alu_n),
    .o_flag_c(o_flag_c), .o_flag_z(o_flag_z), .o_flag_n(o_flag_n),
    .o_flag_we_c(o_flag_we_c), .o_flag_we_zn(o_flag_we_zn)
  );

  // External ALU as the sequencer would see it in a system.
  always_comb begin
    alu_q = o_alu_left;
    alu_c = 1'b0;
    case (o_alu_func)
      4'h8: {alu_c, alu_q} = {o_alu_left, 1'b0};
      4'h9: {alu_q, alu_c} = {1'b0, o_alu_left};
      4'hA: {alu_c, alu_q} = {o_alu_left, o_alu_c};
      4'hB: {alu_q, alu_c} = {o_alu_c, o_alu_left};
      4'h5: begin alu_q = o_alu_left + 8'd1; alu_c = o_alu_c; end
      4'h7: begin alu_q = o_alu_left - 8'd1; alu_c = o_alu_c; end
      default: ;
    endcase
    alu_z = (alu_q == 8'h00);
    alu_n = alu_q[7];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result of a read-modify-write on data d with carry-in cin.
  function automatic void ref_op(input int op, input int d, input int cin,
                                 output int q, output int c);
    q = d;
    c = cin;
    case (op)
      0: begin q = (d * 2) % 256;       c = d / 128; end
      1: begin q = d / 2;               c = d % 2;   end
      2: begin q = (d * 2 + cin) % 256; c = d / 128; end
      3: begin q = d / 2 + cin * 128;   c = d % 2;   end
      4: q = (d + 1) % 256;
      5: q = (d + 255) % 256;
      default: ;
    endcase
  endfunction

  function automatic int exp_func(input int op);
    case (op)
      0: return 8;
      1: return 9;
      2: return 10;
      3: return 11;
      4: return 5;
      default: return 7;
    endcase
  endfunction

  function automatic int dummy_expected();
`ifdef RMW_DUMMY_WRITE_EN
    return 1;
`else
    return 0;
`endif
  endfunction

  task automatic check_outputs_clear(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_rd"}, o_bus_rd, 0);
    chk({tag, "_wr"}, o_bus_wr, 0);
    chk({tag, "_addr"}, o_bus_addr, 0);
    chk({tag, "_wdata"}, o_bus_wdata, 0);
    chk({tag, "_func"}, o_alu_func, 4'hF);
    chk({tag, "_left"}, o_alu_left, 0);
    chk({tag, "_flags"}, {o_flag_c, o_flag_z, o_flag_n, o_flag_we_c, o_flag_we_zn}, 0);
  endtask

  // One full operation: start presented in the current IDLE cycle, then each
  // cycle classified as READ, MODIFY or WRITE from the bus outputs.
  task automatic run_op(input int op, input logic [15:0] addr, input int cin,
                        input logic [7:0] rdata, input int stall);
    int q, c, rd_cyc, mod_cyc, dummies;
    bit seen_done;
    rd_cyc = 0; mod_cyc = 0; dummies = 0; seen_done = 0;
    ref_op(op, int'(rdata), cin, q, c);
    @(negedge clk);
    chk("idle_busy", o_busy, 0);
    chk("idle_func", o_alu_func, 4'hF);
    i_start = 1'b1; i_op = 3'(op); i_addr = addr; i_c = 1'(cin);
    i_rdy = 1'b0; i_bus_rdata = 8'($urandom);
    for (int cyc = 1; cyc <= 20 && !seen_done; cyc++) begin
      @(negedge clk);
      // Junk start requests mid-operation must not disturb the captured command.
      i_start = 1'($urandom); i_op = 3'($urandom_range(0, 5));
      i_addr = 16'($urandom); i_c = 1'($urandom);
      chk("busy", o_busy, 1);
      chk("rd_wr_excl", o_bus_rd & o_bus_wr, 0);
      if (o_bus_rd) begin
        rd_cyc++;
        chk("rd_addr", o_bus_addr, addr);
        chk("rd_func", o_alu_func, 4'hF);
        chk("rd_done", o_done, 0);
        i_rdy = (rd_cyc > stall);
        i_bus_rdata = i_rdy ? rdata : 8'($urandom);
      end else if (o_done) begin
        seen_done = 1;
        i_rdy = 1'($urandom);
        chk("done_cycle", cyc, 3 + stall);
        chk("wr", o_bus_wr, 1);
        chk("wr_addr", o_bus_addr, addr);
        chk("wdata", o_bus_wdata, q);
        chk("flag_z", o_flag_z, (q == 0));
        chk("flag_n", o_flag_n, (q >= 128));
        chk("we_zn", o_flag_we_zn, 1);
        chk("we_c", o_flag_we_c, (op < 4));
        if (op < 4) chk("flag_c", o_flag_c, c);
        chk("wr_func", o_alu_func, 4'hF);
      end else begin
        mod_cyc++;
        i_rdy = 1'($urandom);
        chk("mod_func", o_alu_func, exp_func(op));
        chk("mod_left", o_alu_left, rdata);
        chk("mod_right", o_alu_right, 0);
        chk("mod_c", o_alu_c, cin);
        chk("mod_flag_we", {o_flag_we_c, o_flag_we_zn}, 0);
        chk("mod_wr", o_bus_wr, dummy_expected());
        if (o_bus_wr) begin
          dummies++;
          chk("dummy_data", o_bus_wdata, rdata);
          chk("dummy_addr", o_bus_addr, addr);
        end
      end
    end
    i_start = 1'b0; i_rdy = 1'b0;
    if (!seen_done) chk("timeout_done", 0, 1);
    chk("read_cycles", rd_cyc, stall + 1);
    chk("modify_cycles", mod_cyc, 1);
    chk("dummy_writes", dummies, dummy_expected());
  endtask

  initial begin
    rstn = 1'b1;
    i_start = 1'b0; i_op = 3'd0; i_addr = 16'h0; i_c = 1'b0;
    i_bus_rdata = 8'h0; i_rdy = 1'b0;
    #2 rstn = 1'b0;
    #2 check_outputs_clear("reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    run_op(0, 16'h0200, 0, 8'h81, 0);   // ASL
    run_op(5, 16'h00FF, 0, 8'h01, 0);   // DEC to zero
    run_op(3, 16'h1234, 1, 8'h00, 2);   // ROR with two stalled reads
    run_op(4, 16'h0300, 0, 8'h7F, 0);   // INC across sign
    run_op(1, 16'hFFFF, 1, 8'h01, 1);   // LSR to zero
    run_op(2, 16'h0000, 1, 8'h80, 0);   // ROL carry out

    // Illegal op codes never leave IDLE.
    for (int k = 6; k <= 7; k++) begin
      @(negedge clk);
      i_start = 1'b1; i_op = 3'(k); i_addr = 16'hABCD;
      repeat (3) begin
        @(negedge clk);
        chk("illegal_busy", o_busy, 0);
        chk("illegal_rd", o_bus_rd, 0);
        chk("illegal_wr", o_bus_wr, 0);
      end
      i_start = 1'b0;
    end

    // Reset asserted during MODIFY aborts the operation.
    @(negedge clk);
    i_start = 1'b1; i_op = 3'd4; i_addr = 16'h0400; i_c = 1'b0; i_rdy = 1'b1;
    i_bus_rdata = 8'h10;
    @(negedge clk);
    i_start = 1'b0;
    chk("abort_read", o_bus_rd, 1);
    @(negedge clk);
    chk("abort_in_modify", o_alu_func, 4'h5);
    rstn = 1'b0;
    #1 check_outputs_clear("abort_reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("abort_wr", o_bus_wr, 0);
      chk("abort_done", o_done, 0);
      chk("abort_func", o_alu_func, 4'hF);
      chk("abort_busy", o_busy, 0);
    end

    // Random back-to-back operations.
    for (int t = 0; t < 40; t++) begin
      run_op($urandom_range(0, 5), 16'($urandom), $urandom_range(0, 1),
             8'($urandom), $urandom_range(0, 3));
    end

    @(negedge clk);
    chk("final_idle", o_busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
